// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the two-master memory bus arbiter.
package mem_bus_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b01;
  localparam logic [1:0] OWNER_M1   = 2'b10;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Avalon-style read/write port with waitrequest and byteenable.
interface mem_bus_arbiter_if import mem_bus_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   readdata;
  logic                waitrequest;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, waitrequest
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie, grants the master that did not own last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       grant,
  output logic       valid
);

  assign valid = |req;
  assign grant = (&req) ? ~last_owner : req[1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for two Avalon masters onto one slave, with a stall watchdog
// that completes hung accesses with ERR_DATA and a sticky bus_error.
module mem_bus_arbiter import mem_bus_pkg::*; #(
  parameter int unsigned       ADDR_W         = ADDR_W_DEF,
  parameter int unsigned       DATA_W         = DATA_W_DEF,
  parameter int unsigned       TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0] ERR_DATA       = ERR_DATA_DEF
) (
  input  logic             clk,
  input  logic             reset,
  mem_bus_arbiter_if.slave  m0,
  mem_bus_arbiter_if.slave  m1,
  mem_bus_arbiter_if.master s,
  output logic [1:0]       owner,
  output logic             bus_error
);

  localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_t          state;
  logic                last_owner;
  logic [CNT_W-1:0]    stall_cnt;

  logic                req0, req1;
  logic                sel_req, sel_read, sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_be;
  logic                timeout, done;
  logic [1:0]          pick_req;
  logic                pick_last, pick_grant, pick_valid;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  always_comb begin
    sel_req   = 1'b0;
    sel_read  = 1'b0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    case (state)
      OWN0: begin
        sel_req   = req0;
        sel_read  = m0.read;
        sel_write = m0.write;
        sel_addr  = m0.address;
        sel_wdata = m0.writedata;
        sel_be    = m0.byteenable;
      end
      OWN1: begin
        sel_req   = req1;
        sel_read  = m1.read;
        sel_write = m1.write;
        sel_addr  = m1.address;
        sel_wdata = m1.writedata;
        sel_be    = m1.byteenable;
      end
      default: ;
    endcase
  end

  assign timeout = sel_req & s.waitrequest & (stall_cnt == CNT_LIMIT);
  assign done    = sel_req & (~s.waitrequest | timeout);

  // At completion only the other master may take over; the current owner goes
  // through IDLE, so its own request is masked out of the picker.
  always_comb begin
    pick_req  = {req1, req0};
    pick_last = last_owner;
    if (state == OWN0) begin
      pick_req  = {req1, 1'b0};
      pick_last = 1'b0;
    end else if (state == OWN1) begin
      pick_req  = {1'b0, req0};
      pick_last = 1'b1;
    end
  end

  rr_pick2 u_pick (
    .req        (pick_req),
    .last_owner (pick_last),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      stall_cnt  <= '0;
      bus_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) state <= pick_grant ? OWN1 : OWN0;
        end
        OWN0, OWN1: begin
          if (done) begin
            last_owner <= (state == OWN1);
            stall_cnt  <= '0;
            if (timeout) bus_error <= 1'b1;
            state <= pick_valid ? (pick_grant ? OWN1 : OWN0) : IDLE;
          end else if (!sel_req) begin
            stall_cnt <= '0;
            state     <= IDLE;
          end else begin
            stall_cnt <= stall_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s.address      = sel_addr;
    s.writedata    = sel_wdata;
    s.byteenable   = sel_be;
    s.write        = sel_write & ~timeout;
    s.read         = sel_read & ~sel_write & ~timeout;
    m0.waitrequest = 1'b1;
    m0.readdata    = '0;
    m1.waitrequest = 1'b1;
    m1.readdata    = '0;
    owner          = OWNER_NONE;
    if (state == OWN0) begin
      owner          = OWNER_M0;
      m0.waitrequest = s.waitrequest & ~timeout;
      m0.readdata    = timeout ? ERR_DATA : s.readdata;
    end else if (state == OWN1) begin
      owner          = OWNER_M1;
      m1.waitrequest = s.waitrequest & ~timeout;
      m1.readdata    = timeout ? ERR_DATA : s.readdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (TIMEOUT_CYCLES = 4).
module tb_mem_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] owner;
  logic       bus_error;
  int         checks;
  int         passed;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_bus ();
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_bus ();
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_bus ();

  mem_bus_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (4),
    .ERR_DATA       (32'hDEADBEEF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .s         (s_bus),
    .owner     (owner),
    .bus_error (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic clear_inputs();
    m0_bus.address = '0; m0_bus.read = 1'b0; m0_bus.write = 1'b0;
    m0_bus.writedata = '0; m0_bus.byteenable = '0;
    m1_bus.address = '0; m1_bus.read = 1'b0; m1_bus.write = 1'b0;
    m1_bus.writedata = '0; m1_bus.byteenable = '0;
    s_bus.readdata = '0; s_bus.waitrequest = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    m0_bus.read = 1'b1;
    m0_bus.address = 32'h0000_1234;
    s_bus.readdata = 32'h5555_AAAA;
    step();
    checks++; if (owner !== 2'b00) $display("FAIL rst_owner got=%b exp=00", owner); else passed++;
    checks++; if (s_bus.read !== 1'b0) $display("FAIL rst_s_read got=%b exp=0", s_bus.read); else passed++;
    checks++; if (s_bus.address !== 32'h0) $display("FAIL rst_s_address got=%h exp=0", s_bus.address); else passed++;
    checks++; if (m0_bus.waitrequest !== 1'b1) $display("FAIL rst_m0_wait got=%b exp=1", m0_bus.waitrequest); else passed++;
    checks++; if (m1_bus.waitrequest !== 1'b1) $display("FAIL rst_m1_wait got=%b exp=1", m1_bus.waitrequest); else passed++;
    checks++; if (m0_bus.readdata !== 32'h0) $display("FAIL rst_m0_rdata got=%h exp=0", m0_bus.readdata); else passed++;
    checks++; if (bus_error !== 1'b0) $display("FAIL rst_bus_error got=%b exp=0", bus_error); else passed++;
    reset = 1'b0;
    clear_inputs();
    step();
  endtask

  task automatic test_single_read();
    do_reset();
    m0_bus.read = 1'b1;
    m0_bus.address = 32'hBFC0_0000;
    s_bus.waitrequest = 1'b0;
    s_bus.readdata = 32'h0000_1122;
    #1;
    checks++; if (owner !== 2'b00) $display("FAIL rd_latency_owner got=%b exp=00", owner); else passed++;
    checks++; if (m0_bus.waitrequest !== 1'b1) $display("FAIL rd_latency_wait got=%b exp=1", m0_bus.waitrequest); else passed++;
    step();
    checks++; if (owner !== 2'b01) $display("FAIL rd_owner got=%b exp=01", owner); else passed++;
    checks++; if (s_bus.read !== 1'b1) $display("FAIL rd_s_read got=%b exp=1", s_bus.read); else passed++;
    checks++; if (s_bus.address !== 32'hBFC0_0000) $display("FAIL rd_s_address got=%h exp=bfc00000", s_bus.address); else passed++;
    checks++; if (m0_bus.waitrequest !== 1'b0) $display("FAIL rd_m0_wait got=%b exp=0", m0_bus.waitrequest); else passed++;
    checks++; if (m0_bus.readdata !== 32'h0000_1122) $display("FAIL rd_m0_rdata got=%h exp=00001122", m0_bus.readdata); else passed++;
    checks++; if (m1_bus.waitrequest !== 1'b1) $display("FAIL rd_m1_wait got=%b exp=1", m1_bus.waitrequest); else passed++;
    step();
    m0_bus.read = 1'b0;
    #1;
    checks++; if (owner !== 2'b00) $display("FAIL rd_back_idle got=%b exp=00", owner); else passed++;
    clear_inputs();
  endtask

  task automatic test_contention();
    logic [1:0]  exp_owner;
    logic [31:0] exp_addr;
    do_reset();
    m0_bus.read = 1'b1; m0_bus.address = 32'h0000_1000;
    m1_bus.read = 1'b1; m1_bus.address = 32'h0000_2000;
    s_bus.waitrequest = 1'b0;
    s_bus.readdata = 32'hA5A5_A5A5;
    step();
    for (int i = 0; i < 6; i++) begin
      exp_owner = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr  = (i % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000;
      #1;
      checks++; if (owner !== exp_owner) $display("FAIL rr_owner[%0d] got=%b exp=%b", i, owner, exp_owner); else passed++;
      checks++; if (s_bus.address !== exp_addr) $display("FAIL rr_addr[%0d] got=%h exp=%h", i, s_bus.address, exp_addr); else passed++;
      checks++; if (m1_bus.waitrequest !== (i % 2 == 0)) $display("FAIL rr_m1_wait[%0d] got=%b exp=%b", i, m1_bus.waitrequest, (i % 2 == 0)); else passed++;
      checks++; if (m0_bus.waitrequest !== (i % 2 != 0)) $display("FAIL rr_m0_wait[%0d] got=%b exp=%b", i, m0_bus.waitrequest, (i % 2 != 0)); else passed++;
      step();
    end
    clear_inputs();
    step();
  endtask

  task automatic test_byte_write();
    logic exp_wait;
    do_reset();
    m1_bus.write = 1'b1;
    m1_bus.address = 32'h0000_0100;
    m1_bus.byteenable = 4'b0011;
    m1_bus.writedata = 32'h0000_FFEE;
    s_bus.waitrequest = 1'b1;
    step();
    m0_bus.read = 1'b1;
    m0_bus.address = 32'h0000_0040;
    for (int i = 0; i < 4; i++) begin
      exp_wait = (i < 3);
      s_bus.waitrequest = exp_wait;
      #1;
      checks++; if (owner !== 2'b10) $display("FAIL wr_owner[%0d] got=%b exp=10", i, owner); else passed++;
      checks++; if (s_bus.write !== 1'b1) $display("FAIL wr_s_write[%0d] got=%b exp=1", i, s_bus.write); else passed++;
      checks++; if (s_bus.byteenable !== 4'b0011) $display("FAIL wr_s_be[%0d] got=%b exp=0011", i, s_bus.byteenable); else passed++;
      checks++; if (s_bus.writedata !== 32'h0000_FFEE) $display("FAIL wr_s_wdata[%0d] got=%h exp=0000ffee", i, s_bus.writedata); else passed++;
      checks++; if (s_bus.address !== 32'h0000_0100) $display("FAIL wr_s_addr[%0d] got=%h exp=00000100", i, s_bus.address); else passed++;
      checks++; if (m1_bus.waitrequest !== exp_wait) $display("FAIL wr_m1_wait[%0d] got=%b exp=%b", i, m1_bus.waitrequest, exp_wait); else passed++;
      checks++; if (m0_bus.waitrequest !== 1'b1) $display("FAIL wr_m0_blocked[%0d] got=%b exp=1", i, m0_bus.waitrequest); else passed++;
      step();
    end
    m1_bus.write = 1'b0;
    #1;
    checks++; if (owner !== 2'b01) $display("FAIL wr_handoff_owner got=%b exp=01", owner); else passed++;
    clear_inputs();
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    m0_bus.read = 1'b1;
    m0_bus.address = 32'h0000_0080;
    s_bus.waitrequest = 1'b1;
    s_bus.readdata = 32'h1234_5678;
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (m0_bus.waitrequest !== 1'b1) $display("FAIL to_stall_wait[%0d] got=%b exp=1", i, m0_bus.waitrequest); else passed++;
      checks++; if (s_bus.read !== 1'b1) $display("FAIL to_stall_read[%0d] got=%b exp=1", i, s_bus.read); else passed++;
      step();
    end
    #1;
    checks++; if (m0_bus.waitrequest !== 1'b0) $display("FAIL to_forced_wait got=%b exp=0", m0_bus.waitrequest); else passed++;
    checks++; if (m0_bus.readdata !== 32'hDEAD_BEEF) $display("FAIL to_err_data got=%h exp=deadbeef", m0_bus.readdata); else passed++;
    checks++; if (s_bus.read !== 1'b0) $display("FAIL to_s_read got=%b exp=0", s_bus.read); else passed++;
    checks++; if (m1_bus.readdata !== 32'h0) $display("FAIL to_m1_rdata got=%h exp=0", m1_bus.readdata); else passed++;
    step();
    m0_bus.read = 1'b0;
    #1;
    checks++; if (bus_error !== 1'b1) $display("FAIL to_bus_error got=%b exp=1", bus_error); else passed++;
    checks++; if (owner !== 2'b00) $display("FAIL to_owner_idle got=%b exp=00", owner); else passed++;
    s_bus.waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++; if (bus_error !== 1'b1) $display("FAIL to_sticky got=%b exp=1", bus_error); else passed++;
  endtask

  task automatic test_reset_mid_transfer();
    clear_inputs();
    m1_bus.write = 1'b1;
    m1_bus.address = 32'h0000_0200;
    m1_bus.writedata = 32'h0000_0001;
    m1_bus.byteenable = 4'b1111;
    s_bus.waitrequest = 1'b1;
    step();
    #1;
    checks++; if (s_bus.write !== 1'b1) $display("FAIL mid_pre_write got=%b exp=1", s_bus.write); else passed++;
    checks++; if (owner !== 2'b10) $display("FAIL mid_pre_owner got=%b exp=10", owner); else passed++;
    #2;
    reset = 1'b1;
    m0_bus.read = 1'b1;
    #1;
    checks++; if (s_bus.write !== 1'b0) $display("FAIL mid_s_write got=%b exp=0", s_bus.write); else passed++;
    checks++; if (m0_bus.waitrequest !== 1'b1) $display("FAIL mid_m0_wait got=%b exp=1", m0_bus.waitrequest); else passed++;
    checks++; if (m1_bus.waitrequest !== 1'b1) $display("FAIL mid_m1_wait got=%b exp=1", m1_bus.waitrequest); else passed++;
    checks++; if (owner !== 2'b00) $display("FAIL mid_owner got=%b exp=00", owner); else passed++;
    checks++; if (bus_error !== 1'b0) $display("FAIL mid_bus_error got=%b exp=0", bus_error); else passed++;
    @(negedge clk);
    reset = 1'b0;
    s_bus.waitrequest = 1'b0;
    step();
    checks++; if (owner !== 2'b01) $display("FAIL mid_first_tie got=%b exp=01", owner); else passed++;
    clear_inputs();
    step();
  endtask

  task automatic test_read_write();
    do_reset();
    m0_bus.read = 1'b1;
    m0_bus.write = 1'b1;
    m0_bus.address = 32'h0000_0300;
    m0_bus.writedata = 32'hCAFE_0000;
    m0_bus.byteenable = 4'b1100;
    s_bus.waitrequest = 1'b0;
    step();
    checks++; if (owner !== 2'b01) $display("FAIL rw_owner got=%b exp=01", owner); else passed++;
    checks++; if (s_bus.write !== 1'b1) $display("FAIL rw_s_write got=%b exp=1", s_bus.write); else passed++;
    checks++; if (s_bus.read !== 1'b0) $display("FAIL rw_s_read got=%b exp=0", s_bus.read); else passed++;
    step();
    clear_inputs();
    step();
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_byte_write();
    test_timeout();
    test_reset_mid_transfer();
    test_read_write();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-master, one-slave arbiter for the CPU memory bus, which uses Avalon-style read, write, waitrequest and byteenable signalling. Master 0 is instruction fetch and master 1 is the data load/store port. Both share a single RAM/slave port. The block uses round-robin ownership and passes the owning master's bus through combinationally. A wait-state watchdog completes any hung slave access with an error.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byteenable width = DATA_W/8)
TIMEOUT_CYCLES, 64, max consecutive stalled cycles per access before forced completion
ERR_DATA, 32'hDEADBEEF, readdata returned on a timed-out read

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
m0_address / m1_address  in  ADDR_W  master byte address
m0_read / m1_read  in  1  read request
m0_write / m1_write  in  1  write request
m0_writedata / m1_writedata  in  DATA_W  write data
m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes
m0_readdata / m1_readdata  out  DATA_W  read data, valid when own waitrequest low
m0_waitrequest / m1_waitrequest  out  1  stall to master
s_address  out  ADDR_W  to slave
s_read / s_write  out  1  to slave
s_writedata  out  DATA_W  to slave
s_byteenable  out  DATA_W/8  to slave
s_readdata  in  DATA_W  from slave
s_waitrequest  in  1  slave stall
owner  out  2  2'b00 idle, 2'b01 m0, 2'b10 m1
bus_error  out  1  sticky timeout flag

Behaviour:
- Request for master x: req_x = mx_read | mx_write. If both read and write are asserted, write wins and s_read is 0.
- State register: IDLE, OWN0, OWN1. Also registered: last_owner (1 bit) and a stall counter of width clog2(TIMEOUT_CYCLES+1).
- Reset (async, any time including mid-transfer) takes effect immediately:
  - state=IDLE, last_owner=1 (so m0 wins the first tie), counter=0, bus_error=0.
  - Outputs: s_read=s_write=0, s_byteenable=0, s_address=0, s_writedata=0, mx_waitrequest=1, mx_readdata=0, owner=0.
- IDLE:
  - Slave outputs are driven 0 and both waitrequests are high.
  - Next state is OWN of the single requester. If both request, OWN of the master that is not last_owner. If neither requests, stay in IDLE.
  - Grant latency: 1 cycle from request to slave visibility.
- OWNx:
  - s_* = mx_* combinationally.
  - mx_waitrequest = s_waitrequest; mx_readdata = s_readdata.
  - The other master's waitrequest is held at 1 and its readdata at 0.
- Completion: a cycle in OWNx with req_x=1 and s_waitrequest=0.
  - last_owner <= x and counter <= 0.
  - Next state is OWN(other) if the other master is requesting, else IDLE.
  - This gives back-to-back alternation under contention; a single master alone gets 1 transfer per 2 cycles.
- Master drops its request while in OWNx (protocol violation): the slave sees the drop immediately, next state is IDLE, last_owner is unchanged.
- Watchdog:
  - In OWNx with req_x=1 and s_waitrequest=1, the counter increments.
  - When counter == TIMEOUT_CYCLES in that cycle:
    - force s_read=s_write=0;
    - force mx_waitrequest=0;
    - force mx_readdata=ERR_DATA;
    - set bus_error<=1;
    - treat the cycle as a completion.
  - bus_error clears only on reset.
- owner reflects the current state combinationally.
- No buffering: the arbiter adds no data latency beyond grant.

Decomposition:
- Package mem_bus_pkg:
  - arb_state_t enum {IDLE, OWN0, OWN1};
  - owner encodings;
  - ERR_DATA default;
  - bus width localparams.
- One sub-module, rr_pick2: combinational 2-way round-robin picker (req[1:0], last_owner → grant index, valid). It is shared by the IDLE and completion transitions.

Test Plan:
1. Single read: m0_read=1, addr 32'hBFC00000, slave waitrequest low immediately, s_readdata=32'h00001122 → owner=01 one cycle later; m0_waitrequest low that cycle with m0_readdata=32'h00001122; next state IDLE.
2. Contention: m0 and m1 both request continuously, slave zero-wait → grants alternate m0,m1,m0,m1 every cycle after the first; m1 sees waitrequest=1 whenever m0 owns.
3. Byte-enabled write: m1_write=1, byteenable=4'b0011, writedata=32'h0000FFEE, slave stalls 3 cycles → s_* mirror m1 for 4 cycles; m1_waitrequest high 3 cycles then low; m0 is blocked throughout.
4. Timeout: TIMEOUT_CYCLES=4, slave holds waitrequest=1 for a m0 read → after 4 stalled cycles m0_waitrequest=0 with m0_readdata=32'hDEADBEEF, s_read=0, bus_error=1 and stays 1.
5. Reset mid-transfer: assert reset asynchronously in OWN1 while the slave stalls → immediately s_write=0, both waitrequests=1, owner=0, bus_error=0; after release m0 wins the first tie.
6. Read+write asserted together on m0 → s_write=1, s_read=0.
